// File: rtl/sum_accumulator.sv
// Accumulates 33-bit adder beats {carry, sum} into a wide batch total and hands it off through a valid/ready result register.
// Optional SUM_ACC_SATURATE_EN: clamp the accumulator to all-ones on overflow instead of wrapping.
module sum_accumulator #(
    parameter int unsigned ACC_W = 40,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [31:0]      in_sum,
    input  logic             in_carry,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_count,
    output logic             out_overflow,
    output logic             out_forced
);

    localparam int unsigned SUM_W = ACC_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [ACC_W-1:0]  acc, acc_next;
    logic [CNT_W-1:0]  count, count_next;
    logic              sticky, sticky_next;
    logic              valid_next;
    logic [ACC_W-1:0]  res_acc_next;
    logic [CNT_W-1:0]  res_count_next;
    logic              res_ovf_next;
    logic              res_forced_next;

    logic              accept;
    logic [SUM_W-1:0]  beat;
    logic [SUM_W-1:0]  sum;
    logic              ovf;
    logic [CNT_W-1:0]  count_inc;
    logic              limit;
    logic              close;
    logic [ACC_W-1:0]  acc_upd;

    // Accumulator and count are always empty outside ACCUM, so a HOLD hand-off beat adds onto zero.
    assign in_ready  = (state != HOLD) || out_ready;
    assign accept    = in_valid && in_ready;
    assign beat      = SUM_W'({in_carry, in_sum});
    assign sum       = SUM_W'(acc) + beat;
    assign ovf       = sum[ACC_W];
    assign count_inc = count + CNT_W'(1);
    assign limit     = (count_inc == CNT_MAX);
    assign close     = in_last || limit;

`ifdef SUM_ACC_SATURATE_EN
    assign acc_upd = (ovf || sticky) ? '1 : sum[ACC_W-1:0];
`else
    assign acc_upd = sum[ACC_W-1:0];
`endif

    // Next-state and result-register logic
    always_comb begin
        state_next      = state;
        acc_next        = acc;
        count_next      = count;
        sticky_next     = sticky;
        valid_next      = out_valid;
        res_acc_next    = out_acc;
        res_count_next  = out_count;
        res_ovf_next    = out_overflow;
        res_forced_next = out_forced;

        case (state)
            HOLD: begin
                if (out_ready) begin
                    valid_next = 1'b0;
                    state_next = IDLE;
                end
            end
            default: ;
        endcase

        if (accept) begin
            if (close) begin
                valid_next      = 1'b1;
                res_acc_next    = acc_upd;
                res_count_next  = count_inc;
                res_ovf_next    = sticky || ovf;
                res_forced_next = !in_last;
                acc_next        = '0;
                count_next      = '0;
                sticky_next     = 1'b0;
                state_next      = HOLD;
            end else begin
                acc_next    = acc_upd;
                count_next  = count_inc;
                sticky_next = sticky || ovf;
                state_next  = ACCUM;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            acc          <= '0;
            count        <= '0;
            sticky       <= 1'b0;
            out_valid    <= 1'b0;
            out_acc      <= '0;
            out_count    <= '0;
            out_overflow <= 1'b0;
            out_forced   <= 1'b0;
        end else begin
            state        <= state_next;
            acc          <= acc_next;
            count        <= count_next;
            sticky       <= sticky_next;
            out_valid    <= valid_next;
            out_acc      <= res_acc_next;
            out_count    <= res_count_next;
            out_overflow <= res_ovf_next;
            out_forced   <= res_forced_next;
        end
    end

endmodule

// File: doc/sum_accumulator.md
Name: sum_accumulator

Overview:
- Stage directly downstream of the two-stage 32-bit adder.
- Takes each registered sum/carry result as one 33-bit beat and accumulates beats into a wide accumulator across a batch.
- Batch ends on in_last or when the beat-count limit is reached.
- Hands the batch total, beat count and status flags downstream through a valid/ready output register.

Parameters:
- ACC_W, 40: accumulator and out_acc width; legal range 33..64.
- CNT_W, 8: beat counter width; maximum batch length is 2^CNT_W-1 beats.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  beat present; driven from the adder's valid tag.
- in_sum  input  32  adder out_sum.
- in_carry  input  1  adder out_carry.
- in_last  input  1  beat is the final beat of the batch.
- in_ready  output  1  beat accepted this cycle when in_valid && in_ready.
- out_valid  output  1  result register holds a finished batch.
- out_ready  input  1  downstream accepts the result.
- out_acc  output  ACC_W  batch total.
- out_count  output  CNT_W  number of beats in the batch.
- out_overflow  output  1  sticky: the batch total exceeded 2^ACC_W-1.
- out_forced  output  1  batch was closed by the count limit, not by in_last.

Behaviour:
- Reset (reset=0), asynchronous and immediate:
  - state=IDLE; acc=0; count=0; sticky overflow=0.
  - All outputs 0 except in_ready=1.
  - Reset mid-batch or mid-hold discards all partial data and any pending result.
- Beat value: {in_carry, in_sum}, zero-extended to ACC_W+1 bits. Sum formed as acc + beat at ACC_W+1 bits; bit ACC_W is the overflow indication.
- FSM states:
  - IDLE: acc=0, count=0, no result pending.
  - ACCUM: batch open, count>0.
  - HOLD: result pending with out_valid=1, accumulator empty.
- Transitions:
  - IDLE, accepted beat, in_last=0: acc=beat; count=1 -> ACCUM.
  - IDLE, accepted beat, in_last=1: result register loads beat with count=1 -> HOLD.
  - ACCUM, accepted beat, not closing: acc+=beat; count+=1 -> ACCUM.
  - ACCUM, closing beat: result loads acc+beat, count+1 and flags; acc, count and sticky cleared -> HOLD.
    - Closing beat = in_last=1, or count+1 == 2^CNT_W-1.
    - out_forced=1 only when the close was caused by the count limit with in_last=0.
  - HOLD, out_ready=1, no accepted beat: out_valid=0 -> IDLE.
  - HOLD, out_ready=1, accepted beat: same cycle, result handed off and the beat treated as an IDLE beat. Goes to ACCUM, or stays in HOLD with a new result if in_last=1.
- in_ready:
  - =1 in IDLE and ACCUM.
  - =out_ready in HOLD (combinational).
  - Upstream must not drive in_valid while in_ready=0; any beat offered then is ignored.
- Latency: out_valid asserts the cycle after the closing beat is accepted.
- Output stability: out_acc, out_count, out_overflow and out_forced stay stable while out_valid=1 && out_ready=0.
- in_valid=0 in ACCUM: no change, batch stays open indefinitely.
- in_last with in_valid=0: ignored.
- Overflow: on any ACCUM update whose bit ACC_W is set, the sticky flag sets. out_overflow reports the flag OR'd with the closing beat's own overflow.
- No ACCUM->HOLD transition is blocked; ACCUM never stalls.

Optional Feature:
- SUM_ACC_SATURATE_EN defined: on overflow, acc (and the closing result) clamps to 2^ACC_W-1 and stays clamped for the rest of the batch. out_overflow still reports the event.
- Not defined: acc wraps modulo 2^ACC_W; out_overflow reports the event.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then release -> out_valid=0, out_acc=0, out_count=0, in_ready=1. Assert reset mid-ACCUM -> same values immediately, before the next edge.
- Batch: beats 13100, 9253, 1 (in_last on the third, carry 0) -> one cycle later out_valid=1, out_acc=22354, out_count=3, out_overflow=0, out_forced=0.
- Carry beat: single beat in_sum=0x0FFFFFEE, in_carry=1, in_last=1 -> out_acc=0x10FFFFFEE, out_count=1.
- Backpressure: out_ready=0 in HOLD -> in_ready=0 and outputs stable for 5 cycles. Then out_ready=1 with a beat of 300 and in_last=1 in the same cycle -> first result handed off, next cycle out_acc=300, out_count=1.
- Count limit: with CNT_W=2, three beats of 5 with in_last=0 -> out_acc=15, out_count=3, out_forced=1.
- Overflow: with ACC_W=33, beats 0x1FFFFFFFF and 1 (last) -> out_overflow=1. out_acc=0x1FFFFFFFF with SUM_ACC_SATURATE_EN defined, 0 without it.
